// File: rtl/digitube_pkg.sv
// Shared constants and types for the 4-digit 7-segment scanning driver.
// Provides the blank/off codes, digit-count, bus widths, the hex-to-segment
// table (CG..CA, active-low) and the packed display payload type.
package digitube_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned OUT_W      = NUM_DIGITS + 1 + SEG_W;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [OUT_W-1:0] DIGI_OFF  = 12'h0FF;

    // Hex digit -> {CG,CF,CE,CD,CC,CB,CA}, active-low
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // One complete display image as captured from the peripheral bus
    typedef struct packed {
        logic [NUM_DIGITS*NIB_W-1:0] data;
        logic [NUM_DIGITS-1:0]       dp;
        logic [NUM_DIGITS-1:0]       blank;
    } disp_t;

endpackage

// File: rtl/digitube_driver_hex7seg.sv
// Combinational hex-nibble to 7-segment decoder.
// Ports: hex_i   - 4-bit value to display
//        seg_c_o - segments CG..CA, active-low (combinational)
module hex7seg
    import digitube_pkg::*;
(
    input  logic [NIB_W-1:0] hex_i,
    output logic [SEG_W-1:0] seg_c_o
);

    assign seg_c_o = HEX_SEG[hex_i];

endmodule

// File: rtl/digitube_driver.sv
// Scanning driver for a 4-digit 7-segment display. Captures a display image
// into a pending register on load, promotes it to the active register only at
// a frame boundary (or immediately while dark), and time-multiplexes the
// active image onto a 12-bit {AN3..AN0, DP, CG..CA} bus.
// Ports: clk, rst_n     - clock, async active-low reset
//        enable         - 1 = scan, 0 = display dark
//        load           - one-cycle capture strobe for data_in/dp_in/blank_in
//        data_in        - four hex nibbles, digit k at [4k+3:4k]
//        dp_in, blank_in- per-digit decimal point / blank controls
//        digi_out       - registered scanning bus
//        frame_start    - registered pulse on the first cycle of digit 0
module digitube_driver
    import digitube_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        load,
    input  logic [NUM_DIGITS*NIB_W-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic [NUM_DIGITS-1:0]       blank_in,
    output logic [OUT_W-1:0]            digi_out,
    output logic                        frame_start
);

    localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    disp_t            pend_q, pend_d;
    disp_t            act_q, act_d;
    logic             pend_valid_q, pend_valid_d;
    logic [OUT_W-1:0] digi_out_q, digi_out_d;
    logic             frame_start_q, frame_start_d;

    logic             tick_c;
    logic             wrap_c;
    logic             copy_c;
    logic [NIB_W-1:0] nib_c;
    logic [SEG_W-1:0] seg_c;

    // Nibble of the active image for the digit currently being scanned
    assign nib_c = act_q.data[NIB_W*32'(idx_q) +: NIB_W];

    hex7seg u_hex7seg (
        .hex_i   (nib_c),
        .seg_c_o (seg_c)
    );

    // Scan timing and pending/active image handoff
    always_comb begin
        tick_c       = (div_cnt_q == CNT_LAST);
        wrap_c       = tick_c && (idx_q == IDX_LAST);
        // While dark there is no frame to tear, so promote pending at once
        copy_c       = pend_valid_q && (enable ? wrap_c : 1'b1);
        div_cnt_d    = '0;
        idx_d        = '0;
        if (enable) begin
            div_cnt_d = tick_c ? '0 : div_cnt_q + CNT_W'(1);
            idx_d     = tick_c ? idx_q + IDX_W'(1) : idx_q;
        end
        act_d        = copy_c ? pend_q : act_q;
        pend_d       = load ? disp_t'{data: data_in, dp: dp_in, blank: blank_in} : pend_q;
        // A load coinciding with a promotion keeps the new image pending
        pend_valid_d = load | (pend_valid_q & ~copy_c);
    end

    // Output composition for the current digit
    always_comb begin
        digi_out_d    = DIGI_OFF;
        frame_start_d = 1'b0;
        if (enable) begin
            digi_out_d = {NUM_DIGITS'(1) << idx_q, ~act_q.dp[idx_q], seg_c};
            if (act_q.blank[idx_q]) begin
                digi_out_d[SEG_W]        = 1'b1;
                digi_out_d[SEG_W-1:0]    = SEG_BLANK;
            end
            frame_start_d = (idx_q == '0) && (div_cnt_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            idx_q         <= '0;
            pend_q        <= '0;
            act_q         <= '0;
            pend_valid_q  <= 1'b0;
            digi_out_q    <= DIGI_OFF;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            idx_q         <= idx_d;
            pend_q        <= pend_d;
            act_q         <= act_d;
            pend_valid_q  <= pend_valid_d;
            digi_out_q    <= digi_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign digi_out    = digi_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digitube_driver.sv
// Self-checking bench for digitube_driver with SCAN_DIV = 4. A frame-position
// model predicts every output cycle; literal checks pin the model at the
// directed scenarios, followed by a randomized soak.
module tb_digitube_driver;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [11:0] digi_out;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    digitube_driver #(.SCAN_DIV(SD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .digi_out    (digi_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: position within the frame plus shown/queued images
    int          phase;
    logic [15:0] m_act_data, m_pen_data;
    logic [3:0]  m_act_dp, m_pen_dp, m_act_blank, m_pen_blank;
    bit          m_pv;
    logic [11:0] exp_out;
    logic        exp_fs;

    bit          lit_en = 1'b0;
    logic [11:0] lit_val;
    logic        lit_fs;
    string       lit_name = "";

    function automatic logic [11:0] compose(input int d, input logic [15:0] data,
                                            input logic [3:0] dp, input logic [3:0] blank);
        logic [3:0]  nib;
        logic [11:0] r;
        nib = 4'((data >> (4 * d)) & 16'hF);
        r   = {4'(1 << d), ~dp[d], seg_tab[nib]};
        if (blank[d]) r[7:0] = 8'hFF;
        return r;
    endfunction

    task automatic model_reset();
        phase       = 0;
        m_act_data  = '0; m_act_dp = '0; m_act_blank = '0;
        m_pen_data  = '0; m_pen_dp = '0; m_pen_blank = '0;
        m_pv        = 1'b0;
        exp_out     = 12'h0FF;
        exp_fs      = 1'b0;
    endtask

    // Predict the outputs registered at this clock edge
    task automatic model_step();
        bit copy;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!enable) begin
            exp_out = 12'h0FF;
            exp_fs  = 1'b0;
            phase   = 0;
            copy    = m_pv;
        end else begin
            exp_out = compose(phase / SD, m_act_data, m_act_dp, m_act_blank);
            exp_fs  = (phase == 0);
            copy    = m_pv && (phase == FRAME - 1);
            phase   = (phase + 1) % FRAME;
        end
        if (copy) begin
            m_act_data = m_pen_data; m_act_dp = m_pen_dp; m_act_blank = m_pen_blank;
            m_pv = 1'b0;
        end
        if (load) begin
            m_pen_data = data_in; m_pen_dp = dp_in; m_pen_blank = blank_in;
            m_pv = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        lit_en = 1'b0;
        #1;
    endtask

    task automatic lit(input string n, input logic [11:0] v, input logic fs);
        lit_name = n;
        lit_val  = v;
        lit_fs   = fs;
        lit_en   = 1'b1;
    endtask

    task automatic wait_frame();
        for (int i = 0; i <= 2 * FRAME; i++) begin
            tick();
            if (exp_fs) return;
        end
        $display("FAIL wait_frame: no frame start within %0d cycles", 2 * FRAME);
        $fatal(1, "wait_frame timeout");
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data_in  = d;
        dp_in    = p;
        blank_in = b;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    // Single compare process: model every cycle, literals when requested
    always @(negedge clk) begin
        checks++;
        if (digi_out !== exp_out || frame_start !== exp_fs) begin
            errors++;
            $display("FAIL model t=%0t digi_out=%h frame_start=%b expected %h / %b",
                     $time, digi_out, frame_start, exp_out, exp_fs);
        end
        if (lit_en) begin
            checks++;
            if (digi_out !== lit_val || frame_start !== lit_fs) begin
                errors++;
                $display("FAIL %s t=%0t digi_out=%h frame_start=%b expected %h / %b",
                         lit_name, $time, digi_out, frame_start, lit_val, lit_fs);
            end
        end
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; load = 1'b0;
        data_in = '0; dp_in = '0; blank_in = '0;
        model_reset();

        // Reset and free-running scan
        repeat (3) tick();
        lit("reset_out", 12'h0FF, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();            lit("first_after_reset", 12'h1C0, 1'b1);
        repeat (4) tick(); lit("an1_after_reset", 12'h2C0, 1'b0);
        repeat (12) tick(); lit("second_frame", 12'h1C0, 1'b1);

        // Hex decode
        tick();
        do_load(16'hA3F8, 4'b0000, 4'b0000);
        wait_frame();      lit("hex_d0_8", 12'h180, 1'b1);
        repeat (4) tick(); lit("hex_d1_F", 12'h28E, 1'b0);
        repeat (4) tick(); lit("hex_d2_3", 12'h4B0, 1'b0);
        repeat (4) tick(); lit("hex_d3_A", 12'h888, 1'b0);

        // No tearing: load while digit 2 is lit
        wait_frame();
        repeat (8) tick();
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (3) tick(); lit("no_tear_d3_old", 12'h888, 1'b0);
        wait_frame();      lit("no_tear_d0_new", 12'h1F9, 1'b1);
        repeat (12) tick(); lit("no_tear_d3_new", 12'h8F9, 1'b0);

        // Load in the wrap cycle while pending holds another image
        wait_frame();
        repeat (2) tick();
        do_load(16'h5555, 4'b0000, 4'b0000);
        repeat (11) tick();
        do_load(16'h2222, 4'b0000, 4'b0000);
        tick();             lit("boundary_first_5", 12'h192, 1'b1);
        repeat (16) tick(); lit("boundary_then_2", 12'h1A4, 1'b1);

        // Decimal points and blanking
        tick();
        do_load(16'h2222, 4'b0101, 4'b1000);
        wait_frame();      lit("dp_d0", 12'h124, 1'b1);
        repeat (4) tick(); lit("dp_d1", 12'h2A4, 1'b0);
        repeat (4) tick(); lit("dp_d2", 12'h424, 1'b0);
        repeat (4) tick(); lit("blank_d3", 12'h8FF, 1'b0);

        // Disable mid digit 2, load while dark, re-enable
        wait_frame();
        repeat (9) tick();
        enable = 1'b0;
        tick();            lit("disable_off", 12'h0FF, 1'b0);
        do_load(16'h3333, 4'b0000, 4'b0000);
        repeat (3) tick();
        enable = 1'b1;
        tick();            lit("reenable_d0", 12'h1B0, 1'b1);

        // Async reset mid digit 1 with pending data
        wait_frame();
        tick();
        do_load(16'h4444, 4'b0000, 4'b0000);
        repeat (3) tick();
        rst_n = 1'b0;
        model_reset();
        lit("async_reset", 12'h0FF, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();             lit("post_reset_d0", 12'h1C0, 1'b1);
        repeat (12) tick(); lit("post_reset_d3", 12'h8C0, 1'b0);
        wait_frame();       lit("pending_discarded", 12'h1C0, 1'b1);

        // Randomized soak
        for (int i = 0; i < 3000; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            data_in  = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            tick();
        end
        load   = 1'b0;
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2 * FRAME) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
